// File: rtl/tof_ctrl_packet_decoder.sv
// Control-packet decoder: turns inbound write/read/update packets into register-port
// strobes and returns read data as a two-word response packet.
module tof_ctrl_packet_decoder #(
    parameter int unsigned RD_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    output logic [15:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        en_o,
    output logic        wr_o,
    output logic [7:0]  addr_o,
    output logic [15:0] dat_o,
    input  logic [15:0] dat_i,
    input  logic        dat_valid_i,
    output logic        update_o,
    output logic [7:0]  err_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_DATA = 3'd1,
        ST_DO_WRITE = 3'd2,
        ST_DO_READ  = 3'd3,
        ST_WAIT_RD  = 3'd4,
        ST_RSP_HDR  = 3'd5,
        ST_RSP_DAT  = 3'd6,
        ST_DISCARD  = 3'd7
    } state_t;

    localparam logic [3:0] OP_WR    = 4'd1;
    localparam logic [3:0] OP_RD    = 4'd2;
    localparam logic [3:0] OP_UPD   = 4'd3;
    localparam logic [7:0] TMO_LAST = 8'(RD_TIMEOUT - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t      r_state;
    logic        r_live;
    logic [15:0] r_hdr;
    logic [15:0] r_rd_data;
    logic [7:0]  r_cnt;
    logic        r_en;
    logic        r_wr;
    logic [7:0]  r_addr;
    logic [15:0] r_dat;
    logic        r_update;
    logic        r_m_tvalid;
    logic [15:0] r_m_tdata;
    logic        r_m_tlast;
    logic [7:0]  r_err_cnt;
    logic        w_rdy;
    logic        w_acc;
    logic [3:0]  w_op;

    // r_live holds s_tready low until the first edge after reset releases
    assign w_rdy = r_live && ((r_state == ST_IDLE) || (r_state == ST_GET_DATA) ||
                              (r_state == ST_DISCARD));
    assign w_acc = s_tvalid && w_rdy;
    assign w_op  = s_tdata[15:12];

    // Packet FSM with all strobes and response outputs registered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_live     <= 1'b0;
            r_hdr      <= 16'h0000;
            r_rd_data  <= 16'h0000;
            r_cnt      <= 8'd0;
            r_en       <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= 8'h00;
            r_dat      <= 16'h0000;
            r_update   <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= 16'h0000;
            r_m_tlast  <= 1'b0;
            r_err_cnt  <= 8'd0;
        end else begin
            r_live   <= 1'b1;
            r_en     <= 1'b0;
            r_wr     <= 1'b0;
            r_update <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        r_hdr  <= s_tdata;
                        r_addr <= s_tdata[7:0];
                        if ((w_op == OP_WR) && !s_tlast) begin
                            r_state <= ST_GET_DATA;
                        end else if ((w_op == OP_RD) && s_tlast) begin
                            r_state <= ST_DO_READ;
                            r_en    <= 1'b1;
                        end else if ((w_op == OP_UPD) && s_tlast) begin
                            r_update <= 1'b1;
                        end else begin
                            r_err_cnt <= sat_inc(r_err_cnt);
                            r_state   <= s_tlast ? ST_IDLE : ST_DISCARD;
                        end
                    end
                end
                ST_GET_DATA: begin
                    if (w_acc) begin
                        r_dat <= s_tdata;
                        if (s_tlast) begin
                            r_state <= ST_DO_WRITE;
                            r_en    <= 1'b1;
                            r_wr    <= 1'b1;
                        end else begin
                            r_err_cnt <= sat_inc(r_err_cnt);
                            r_state   <= ST_DISCARD;
                        end
                    end
                end
                ST_DO_WRITE: begin
                    r_state <= ST_IDLE;
                end
                ST_DO_READ: begin
                    r_state <= ST_WAIT_RD;
                    r_cnt   <= 8'd0;
                end
                ST_WAIT_RD: begin
                    // valid data wins over a timeout landing on the same cycle
                    if (dat_valid_i || (r_cnt == TMO_LAST)) begin
                        r_rd_data  <= dat_valid_i ? dat_i : 16'hFFFF;
                        r_err_cnt  <= dat_valid_i ? r_err_cnt : sat_inc(r_err_cnt);
                        r_state    <= ST_RSP_HDR;
                        r_m_tvalid <= 1'b1;
                        r_m_tdata  <= r_hdr;
                        r_m_tlast  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RSP_HDR: begin
                    if (m_tready) begin
                        r_state   <= ST_RSP_DAT;
                        r_m_tdata <= r_rd_data;
                        r_m_tlast <= 1'b1;
                    end
                end
                ST_RSP_DAT: begin
                    if (m_tready) begin
                        r_state    <= ST_IDLE;
                        r_m_tvalid <= 1'b0;
                        r_m_tlast  <= 1'b0;
                    end
                end
                ST_DISCARD: begin
                    if (w_acc && s_tlast) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_tready  = w_rdy;
    assign m_tdata   = r_m_tdata;
    assign m_tvalid  = r_m_tvalid;
    assign m_tlast   = r_m_tlast;
    assign en_o      = r_en;
    assign wr_o      = r_wr;
    assign addr_o    = r_addr;
    assign dat_o     = r_dat;
    assign update_o  = r_update;
    assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_tof_ctrl_packet_decoder.sv
// Directed bench for tof_ctrl_packet_decoder: write, read, timeout, back-pressure,
// bad packets with error saturation, update pulse and reset mid-packet.
module tb_tof_ctrl_packet_decoder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] s_tdata = 16'h0000;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic        en_o;
    logic        wr_o;
    logic [7:0]  addr_o;
    logic [15:0] dat_o;
    logic [15:0] dat_i = 16'h0000;
    logic        dat_valid_i = 1'b0;
    logic        update_o;
    logic [7:0]  err_cnt_o;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int upd_cnt = 0;
    int both_cnt = 0;
    int exp_err = 0;
    logic [16:0] rsp_q[$];

    tof_ctrl_packet_decoder #(.RD_TIMEOUT(15)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .en_o(en_o), .wr_o(wr_o), .addr_o(addr_o), .dat_o(dat_o),
        .dat_i(dat_i), .dat_valid_i(dat_valid_i), .update_o(update_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: counts strobes and records response words that transfer at the next edge
    always begin
        @(negedge clk_i);
        #2;
        if (en_o) en_cnt++;
        if (update_o) upd_cnt++;
        if (en_o && update_o) both_cnt++;
        if (m_tvalid && m_tready) rsp_q.push_back({m_tlast, m_tdata});
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        int b;
        b = 0;
        s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
        while (!s_tready && b < 100) begin tick(); b++; end
        if (b >= 100) begin
            checks++; errors++;
            $display("FAIL send_timeout word=%h s_tready never rose", d);
        end
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int b;
        b = 0;
        while (rsp_q.size() < n && b < 100) begin tick(); b++; end
        checks++;
        if (rsp_q.size() < n) begin
            errors++;
            $display("FAIL rsp_wait got=%0d words required=%0d", rsp_q.size(), n);
        end
    endtask

    task automatic check_rsp(input string nm, input logic [16:0] exp);
        logic [16:0] got;
        got = (rsp_q.size() > 0) ? rsp_q.pop_front() : 17'h1DEAD;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", nm, got, exp);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({s_tready, m_tvalid, m_tlast, m_tdata, en_o, wr_o, addr_o, dat_o, update_o, err_cnt_o} !== 60'd0) begin
            errors++;
            $display("FAIL reset_outputs got s_tready=%b m_tvalid=%b en=%b addr=%h dat=%h err=%0d required all 0",
                     s_tready, m_tvalid, en_o, addr_o, dat_o, err_cnt_o);
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (s_tready !== 1'b0) begin errors++; $display("FAIL rdy_before_edge got=%b required=0", s_tready); end
        tick();
        checks++;
        if (s_tready !== 1'b1) begin errors++; $display("FAIL rdy_after_edge got=%b required=1", s_tready); end
    endtask

    task automatic test_write();
        int e0;
        e0 = en_cnt;
        send(16'h1042, 1'b0);
        send(16'h1234, 1'b1);
        checks++;
        if ({en_o, wr_o, addr_o, dat_o} !== {1'b1, 1'b1, 8'h42, 16'h1234}) begin
            errors++;
            $display("FAIL write_strobe got en=%b wr=%b addr=%h dat=%h required 1 1 42 1234", en_o, wr_o, addr_o, dat_o);
        end
        tick();
        checks++;
        if (en_o !== 1'b0) begin errors++; $display("FAIL write_one_cycle got en=%b required=0", en_o); end
        repeat (4) tick();
        checks++;
        if (en_cnt - e0 != 1 || rsp_q.size() != 0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL write_counts got en=%0d rsp=%0d required en=1 rsp=0", en_cnt - e0, rsp_q.size());
        end
    endtask

    task automatic test_read();
        m_tready = 1'b1;
        dat_valid_i = 1'b1; dat_i = 16'h1111;
        tick();
        dat_valid_i = 1'b0;
        send(16'h2005, 1'b1);
        checks++;
        if ({en_o, wr_o, addr_o} !== {1'b1, 1'b0, 8'h05}) begin
            errors++;
            $display("FAIL read_strobe got en=%b wr=%b addr=%h required 1 0 05", en_o, wr_o, addr_o);
        end
        tick();
        tick();
        dat_valid_i = 1'b1; dat_i = 16'hBEEF;
        tick();
        dat_valid_i = 1'b0;
        wait_rsp(2);
        check_rsp("read_hdr", {1'b0, 16'h2005});
        check_rsp("read_dat", {1'b1, 16'hBEEF});
        checks++;
        if (err_cnt_o !== 8'(exp_err)) begin errors++; $display("FAIL read_err got=%0d required=%0d", err_cnt_o, exp_err); end
    endtask

    task automatic test_timeout();
        send(16'h2010, 1'b1);
        wait_rsp(2);
        check_rsp("tmo_hdr", {1'b0, 16'h2010});
        check_rsp("tmo_dat", {1'b1, 16'hFFFF});
        exp_err++;
        checks++;
        if (err_cnt_o !== 8'(exp_err)) begin errors++; $display("FAIL tmo_err got=%0d required=%0d", err_cnt_o, exp_err); end
    endtask

    task automatic test_back_pressure();
        int bad;
        bad = 0;
        m_tready = 1'b0;
        send(16'h2033, 1'b1);
        tick();
        dat_valid_i = 1'b1; dat_i = 16'hCAFE;
        tick();
        dat_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_tvalid !== 1'b1 || m_tdata !== 16'h2033 || m_tlast !== 1'b0 || s_tready !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_stable got %0d unstable cycles required 0", bad); end
        m_tready = 1'b1;
        wait_rsp(2);
        check_rsp("bp_hdr", {1'b0, 16'h2033});
        check_rsp("bp_dat", {1'b1, 16'hCAFE});
    endtask

    task automatic test_update();
        int u0;
        int e0;
        u0 = upd_cnt; e0 = en_cnt;
        send(16'h3000, 1'b1);
        checks++;
        if ({update_o, en_o} !== 2'b10) begin errors++; $display("FAIL upd_pulse got upd=%b en=%b required 1 0", update_o, en_o); end
        repeat (4) tick();
        checks++;
        if (upd_cnt - u0 != 1 || en_cnt - e0 != 0) begin
            errors++;
            $display("FAIL upd_counts got upd=%0d en=%0d required 1 0", upd_cnt - u0, en_cnt - e0);
        end
    endtask

    task automatic test_bad_packets();
        int e0;
        e0 = en_cnt;
        send(16'h7000, 1'b0); send(16'h1111, 1'b0); send(16'h1242, 1'b1);
        exp_err++;
        send(16'h1050, 1'b1);
        exp_err++;
        send(16'h2060, 1'b0); send(16'h0000, 1'b1);
        exp_err++;
        send(16'h1070, 1'b0); send(16'h5555, 1'b0); send(16'h6666, 1'b1);
        exp_err++;
        repeat (2) tick();
        checks++;
        if (err_cnt_o !== 8'(exp_err) || en_cnt != e0) begin
            errors++;
            $display("FAIL bad_pkts got err=%0d en=%0d required err=%0d en=0", err_cnt_o, en_cnt - e0, exp_err);
        end
        send(16'h10AA, 1'b0);
        send(16'h0077, 1'b1);
        checks++;
        if ({en_o, wr_o, addr_o, dat_o} !== {1'b1, 1'b1, 8'hAA, 16'h0077}) begin
            errors++;
            $display("FAIL after_discard got en=%b addr=%h dat=%h required 1 AA 0077", en_o, addr_o, dat_o);
        end
        for (int i = 0; i < 300; i++) begin
            send(16'hF000, 1'b1);
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            if (i == 99) begin
                checks++;
                if (err_cnt_o !== 8'(exp_err)) begin errors++; $display("FAIL err_mid got=%0d required=%0d", err_cnt_o, exp_err); end
            end
        end
        tick();
        checks++;
        if (err_cnt_o !== 8'd255) begin errors++; $display("FAIL err_sat got=%0d required=255", err_cnt_o); end
    endtask

    task automatic test_reset_mid_write();
        int e0;
        send(16'h1099, 1'b0);
        e0 = en_cnt;
        s_tdata = 16'h4444; s_tlast = 1'b1; s_tvalid = 1'b1;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({s_tready, en_o, m_tvalid, update_o, err_cnt_o, addr_o} !== 20'd0) begin
            errors++;
            $display("FAIL rst_async got rdy=%b en=%b err=%0d addr=%h required all 0", s_tready, en_o, err_cnt_o, addr_o);
        end
        exp_err = 0;
        tick(); tick();
        rst_i = 1'b0;
        s_tvalid = 1'b0; s_tlast = 1'b0;
        repeat (4) tick();
        checks++;
        if (en_cnt != e0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_abandon got en=%0d mvalid=%b required 0 0", en_cnt - e0, m_tvalid);
        end
        send(16'h10BB, 1'b0);
        send(16'h0001, 1'b1);
        checks++;
        if ({en_o, addr_o, dat_o, err_cnt_o} !== {1'b1, 8'hBB, 16'h0001, 8'd0}) begin
            errors++;
            $display("FAIL rst_first_hdr got en=%b addr=%h dat=%h err=%0d required 1 BB 0001 0", en_o, addr_o, dat_o, err_cnt_o);
        end
        tick();
        checks++;
        if (both_cnt != 0) begin errors++; $display("FAIL en_upd_overlap got=%0d required=0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_back_pressure();
        test_update();
        test_bad_packets();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
